// File: rtl/mem_pkg.sv
// -----------------------------------------------------------------------------
// mem_pkg
// Shared definitions for the Memory block and its read/write paths.
//   - Default word, address and burst-length widths.
//   - Burst writer FSM state encodings.
// -----------------------------------------------------------------------------
package mem_pkg;

    localparam int MEM_DATA_W = 32;
    localparam int MEM_ADDR_W = 8;
    localparam int MEM_LEN_W  = 9;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_DONE  = 2'd2
    } wr_state_e;

endpackage : mem_pkg

// File: rtl/mem_burst_cnt.sv
// -----------------------------------------------------------------------------
// mem_burst_cnt
// Address / remaining-word counter for one write burst.
// Ports:
//   clock      in   system clock, rising edge
//   reset      in   asynchronous active-low reset
//   load       in   capture load_addr / load_len (command accepted)
//   step       in   one beat accepted: address +1 (wrapping), remaining -1
//   load_addr  in   burst start address
//   load_len   in   burst length in words
//   cur_addr   out  address of the next beat to be written
//   last       out  the next accepted beat is the final one of the burst
// -----------------------------------------------------------------------------
module mem_burst_cnt
    import mem_pkg::*;
#(
    parameter int ADDR_W = MEM_ADDR_W,
    parameter int LEN_W  = MEM_LEN_W
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              load,
    input  logic              step,
    input  logic [ADDR_W-1:0] load_addr,
    input  logic [LEN_W-1:0]  load_len,
    output logic [ADDR_W-1:0] cur_addr,
    output logic              last
);

    logic [ADDR_W-1:0] cur_addr_r;
    logic [LEN_W-1:0]  remaining_r;

    // Address and remaining-word registers; the address wraps naturally at 2^ADDR_W.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cur_addr_r  <= '0;
            remaining_r <= '0;
        end else if (load) begin
            cur_addr_r  <= load_addr;
            remaining_r <= load_len;
        end else if (step) begin
            cur_addr_r  <= cur_addr_r + ADDR_W'(1);
            remaining_r <= remaining_r - LEN_W'(1);
        end else begin
            cur_addr_r  <= cur_addr_r;
            remaining_r <= remaining_r;
        end
    end

    assign cur_addr = cur_addr_r;
    assign last     = (remaining_r == LEN_W'(1));

endmodule : mem_burst_cnt

// File: rtl/mem_burst_writer.sv
// -----------------------------------------------------------------------------
// mem_burst_writer
// Turns a burst command (start address, word count) plus a streamed data
// channel into single-port RAM write cycles. One burst at a time; all
// memory-side outputs are registered (write latency = 1 cycle from acceptance).
// Ports:
//   clock, reset            clock (rising edge), async active-low reset
//   cmd_valid/ready         burst command handshake, cmd_addr / cmd_len payload
//   wr_valid/ready          data beat handshake, wr_data payload
//   mem_we/addr/wdata       RAM write port
//   busy                    burst in progress (cycle after accept .. done cycle)
//   done                    one-cycle pulse with the final write
//   words_written           beats written in the current / last burst
//   checksum                (only with MEM_BURST_WRITER_CHECKSUM_EN) running sum
//                           of accepted beats, modulo 2^DATA_W
// Configuration macro: MEM_BURST_WRITER_CHECKSUM_EN
// -----------------------------------------------------------------------------
module mem_burst_writer
    import mem_pkg::*;
#(
    parameter int DATA_W = MEM_DATA_W,
    parameter int ADDR_W = MEM_ADDR_W,
    parameter int LEN_W  = MEM_LEN_W
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [LEN_W-1:0]  cmd_len,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [DATA_W-1:0] wr_data,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              busy,
    output logic              done,
    output logic [LEN_W-1:0]  words_written
`ifdef MEM_BURST_WRITER_CHECKSUM_EN
    ,
    output logic [DATA_W-1:0] checksum
`endif
);

    wr_state_e         state_r;
    wr_state_e         state_nxt_s;
    logic              accept_cmd_s;
    logic              beat_s;
    logic [ADDR_W-1:0] cur_addr_s;
    logic              last_s;

    logic              mem_we_r;
    logic [ADDR_W-1:0] mem_addr_r;
    logic [DATA_W-1:0] mem_wdata_r;
    logic              busy_r;
    logic              done_r;
    logic [LEN_W-1:0]  words_written_r;

    assign accept_cmd_s = cmd_valid && (state_r == ST_IDLE);
    assign beat_s       = wr_valid && (state_r == ST_WRITE);

    mem_burst_cnt #(
        .ADDR_W (ADDR_W),
        .LEN_W  (LEN_W)
    ) u_cnt (
        .clock     (clock),
        .reset     (reset),
        .load      (accept_cmd_s),
        .step      (beat_s),
        .load_addr (cmd_addr),
        .load_len  (cmd_len),
        .cur_addr  (cur_addr_s),
        .last      (last_s)
    );

    // FSM state register.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // FSM next-state logic; a zero-length command goes straight to DONE.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_cmd_s) begin
                    state_nxt_s = (cmd_len == LEN_W'(0)) ? ST_DONE : ST_WRITE;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_WRITE: begin
                if (beat_s && last_s) begin
                    state_nxt_s = ST_DONE;
                end else begin
                    state_nxt_s = ST_WRITE;
                end
            end
            ST_DONE: begin
                state_nxt_s = ST_IDLE;
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // Registered memory-side and status outputs. done/busy are derived from
    // the next state so they line up with the final registered write.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            mem_we_r        <= 1'b0;
            mem_addr_r      <= '0;
            mem_wdata_r     <= '0;
            busy_r          <= 1'b0;
            done_r          <= 1'b0;
            words_written_r <= '0;
        end else begin
            mem_we_r <= beat_s;
            if (beat_s) begin
                mem_addr_r  <= cur_addr_s;
                mem_wdata_r <= wr_data;
            end
            busy_r <= (state_nxt_s != ST_IDLE);
            done_r <= (state_nxt_s == ST_DONE);
            if (accept_cmd_s) begin
                words_written_r <= '0;
            end else if (beat_s) begin
                words_written_r <= words_written_r + LEN_W'(1);
            end
        end
    end

`ifdef MEM_BURST_WRITER_CHECKSUM_EN
    logic [DATA_W-1:0] checksum_r;

    // Running modulo-2^DATA_W sum of accepted beats, cleared per command.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            checksum_r <= '0;
        end else if (accept_cmd_s) begin
            checksum_r <= '0;
        end else if (beat_s) begin
            checksum_r <= checksum_r + wr_data;
        end else begin
            checksum_r <= checksum_r;
        end
    end

    assign checksum = checksum_r;
`endif

    // Handshake readies decode straight from the state register.
    assign cmd_ready     = (state_r == ST_IDLE);
    assign wr_ready      = (state_r == ST_WRITE);

    assign mem_we        = mem_we_r;
    assign mem_addr      = mem_addr_r;
    assign mem_wdata     = mem_wdata_r;
    assign busy          = busy_r;
    assign done          = done_r;
    assign words_written = words_written_r;

endmodule : mem_burst_writer

// File: doc/mem_burst_writer.md
Name: mem_burst_writer

Overview:
- Write-side counterpart to the existing Memory read path: turns a burst command (start address, word count) plus a streamed data channel into single-port RAM write cycles.
- Sits between a data producer (test pattern generator, UART receiver, etc.) and the RAM write port of Memory, so RAM contents can be loaded before the read path runs.
- One burst at a time.
- Registered memory-side outputs.

Parameters:
- DATA_W, 32, width of data word and RAM word.
- ADDR_W, 8, RAM address width; depth = 2^ADDR_W.
- LEN_W, 9, burst length field width; max burst 2^LEN_W-1 words.

Ports:
- clock  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset (0 = reset).
- cmd_valid  input  1  burst command present.
- cmd_ready  output  1  writer can accept a command.
- cmd_addr  input  ADDR_W  burst start address.
- cmd_len  input  LEN_W  number of words in burst.
- wr_valid  input  1  data beat present.
- wr_ready  output  1  writer accepts a data beat.
- wr_data  input  DATA_W  data beat.
- mem_we  output  1  RAM write enable.
- mem_addr  output  ADDR_W  RAM write address.
- mem_wdata  output  DATA_W  RAM write data.
- busy  output  1  burst in progress.
- done  output  1  one-cycle pulse at burst completion.
- words_written  output  LEN_W  beats written in current/last burst.

Behaviour:
- Reset (reset=0, async assert, sync release):
  - State is IDLE.
  - mem_we, mem_addr, mem_wdata, busy, done and words_written are all 0.
  - cmd_ready=1 after release.
- States: IDLE, WRITE, DONE.
- cmd_ready = (state==IDLE); wr_ready = (state==WRITE). Both decode directly from the state register.
- IDLE, on cmd_valid&cmd_ready:
  - Capture cur_addr=cmd_addr and remaining=cmd_len.
  - Clear words_written.
  - If cmd_len==0, go to DONE with no writes; otherwise go to WRITE.
- WRITE, on wr_valid&wr_ready (accepted beat):
  - Next cycle mem_we=1, mem_addr=cur_addr, mem_wdata=wr_data. Write latency is exactly 1 cycle from acceptance.
  - cur_addr increments modulo 2^ADDR_W: 2^ADDR_W-1 wraps to 0.
  - remaining decrements; words_written increments.
- WRITE, cycle without an accepted beat: mem_we=0 next cycle; mem_addr and mem_wdata hold.
- Last beat accepted (remaining==1): go to DONE.
  - done=1 in the same cycle as the final mem_we=1.
  - Then return to IDLE; cmd_ready=1 the cycle after done.
- Zero-length command: done=1 one cycle after acceptance, mem_we stays 0.
- busy is 1 from the cycle after command acceptance through the done cycle inclusive.
- words_written holds its final value until the next command is accepted.
- Ignored inputs:
  - cmd_valid while busy: no capture, no side effects.
  - wr_data/wr_valid outside WRITE: ignored, never written.
- cmd_len > 2^ADDR_W: addresses wrap and earlier locations are overwritten; no error.
- Reset mid-burst:
  - Burst abandoned; mem_we drops immediately (async).
  - Return to IDLE; partially written RAM contents are not rolled back.
- No back-to-back command overlap: the minimum gap between bursts is the DONE cycle.

Optional Feature:
- Macro: MEM_BURST_WRITER_CHECKSUM_EN.
- Defined:
  - Adds output port checksum (DATA_W): sum modulo 2^DATA_W of all beats accepted in the current burst.
  - Cleared to 0 on command acceptance and on reset.
  - Final value is valid in the done cycle and held until the next command.
- Undefined: the port and its adder are absent; all other behaviour is identical.

Decomposition:
- Shared package mem_pkg:
  - State encodings ST_IDLE=2'd0, ST_WRITE=2'd1, ST_DONE=2'd2.
  - Default DATA_W/ADDR_W/LEN_W constants, shared with Memory and its read path.
- One sub-module: mem_burst_cnt.
  - Holds cur_addr and remaining.
  - Load, decrement/increment-with-wrap, and last-beat flag.
  - The FSM and output registers stay in the top.

Test Plan:
- Basic burst: reset low 20 ns, release; cmd addr=0x10 len=4; data 0xA0..0xA3 with wr_valid held -> mem_we high 4 consecutive cycles at addresses 0x10..0x13 with data 0xA0..0xA3, done pulses with the 4th write, words_written=4.
- Throttled data: addr=0x00 len=3, wr_valid pattern 1,0,0,1,0,1 -> exactly 3 writes, mem_we=0 in gap cycles, addresses 0,1,2 in order, done with the 3rd write.
- Wrap: addr=0xFE len=4 -> writes at 0xFE, 0xFF, 0x00, 0x01.
- Zero length / busy rejection:
  - len=0 -> no mem_we, done one cycle after acceptance.
  - Second cmd_valid asserted during a len=5 burst -> not captured; only 5 writes occur.
- Reset mid-burst: assert reset after 2 of 6 beats -> mem_we, busy and done go 0 immediately. After release, cmd_ready=1 and a new len=1 burst at 0x20 writes once.
- Checksum (macro defined): len=3 data 0xFFFFFFFF, 0x2, 0x3 -> checksum=0x00000004 at done.
